// File: rtl/inv_shift_rows_serial_pkg.sv
// Shared AES byte-serial definitions for the decryption datapath.
// Holds the byte and state sizes, the byte index type, and the source-index
// LUTs for InvShiftRows and its forward counterpart.
// The state is stored column-major, so idx = r + 4c, with r = idx[1:0] and
// c = idx[3:2].
package inv_shift_rows_serial_pkg;

    localparam int AES_BYTE_W      = 8;
    localparam int AES_STATE_BYTES = 16;

    typedef logic [3:0] byte_idx_t;

    // InvShiftRows: out[r+4c] = in[r + 4*((c-r) mod 4)]
    function automatic byte_idx_t inv_shift_rows_src(input byte_idx_t idx);
        logic [1:0] col;
        col = idx[3:2] - idx[1:0];
        return {col, idx[1:0]};
    endfunction

    // ShiftRows (forward stage): out[r+4c] = in[r + 4*((c+r) mod 4)]
    function automatic byte_idx_t shift_rows_src(input byte_idx_t idx);
        logic [1:0] col;
        col = idx[3:2] + idx[1:0];
        return {col, idx[1:0]};
    endfunction

endpackage

// File: rtl/inv_shift_rows_serial_bank.sv
// AES state bank: one 16 x 8 register file holding one AES state.
// It has one synchronous write port and one asynchronous read port.
// Storage is deliberately not reset, because a bank's contents only matter
// once its full flag is set.
// Ports:
//   clk    - clock
//   we     - write enable
//   waddr  - write byte index
//   wdata  - write byte
//   raddr  - read byte index (combinational read)
//   rdata  - read byte
module inv_shift_rows_serial_bank #(
    parameter int DW    = 8,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/inv_shift_rows_serial.sv
// Byte-serial AES InvShiftRows for the decryption datapath.
// The block accepts 16-byte states one byte per cycle in index order 0..15.
// It emits the row-un-rotated state one byte per cycle.
// Two banks form a ping-pong buffer: one bank is filled while the other is
// drained, so the stream runs at full rate while out_ready stays high.
// Ports:
//   clk, rst_n           - clock and asynchronous active-low reset
//   in_valid / in_ready  - input handshake; in_byte is the state byte
//   out_valid / out_ready- output handshake; out_byte is the output byte
//   out_last             - marks output byte 15 of a block
//
// Bank status (per bank b):
//   full[b] | meaning
//   0       | empty or being written by the writer
//   1       | complete state, owned by the reader until byte 15 leaves
module inv_shift_rows_serial
    import inv_shift_rows_serial_pkg::*;
#(
    parameter int DW     = AES_BYTE_W,
    parameter int NBYTES = AES_STATE_BYTES
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_byte,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_byte,
    output logic          out_last
);

    localparam byte_idx_t LAST_IDX = byte_idx_t'(NBYTES - 1);

    logic [1:0]    full;
    logic [1:0]    full_nxt;
    logic          wr_bank;
    logic          rd_bank;
    byte_idx_t     wr_idx;
    byte_idx_t     rd_idx;
    byte_idx_t     rd_src;
    logic          wr_fire;
    logic          rd_fire;
    logic [DW-1:0] rd_data [2];

    // in_ready depends only on registered state, so there is no path from
    // out_ready to in_ready.
    assign in_ready  = !full[wr_bank];
    assign wr_fire   = in_valid && in_ready;
    assign out_valid = full[rd_bank];
    assign rd_fire   = out_valid && out_ready;
    assign out_last  = out_valid && (rd_idx == LAST_IDX);
    assign rd_src    = inv_shift_rows_src(rd_idx);
    assign out_byte  = rd_data[rd_bank];

    for (genvar b = 0; b < 2; b++) begin : g_bank
        inv_shift_rows_serial_bank #(
            .DW    (DW),
            .DEPTH (NBYTES)
        ) u_bank (
            .clk   (clk),
            .we    (wr_fire && (wr_bank == 1'(b))),
            .waddr (wr_idx),
            .wdata (in_byte),
            .raddr (rd_src),
            .rdata (rd_data[b])
        );
    end

    // The writer only targets an empty bank and the reader only targets a
    // full one. A set and a clear on the same edge therefore always hit
    // different banks, and both take effect.
    always_comb begin
        full_nxt = full;
        if (rd_fire && (rd_idx == LAST_IDX)) begin
            full_nxt[rd_bank] = 1'b0;
        end
        if (wr_fire && (wr_idx == LAST_IDX)) begin
            full_nxt[wr_bank] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full    <= 2'b00;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            wr_idx  <= '0;
            rd_idx  <= '0;
        end else begin
            full <= full_nxt;
            if (wr_fire) begin
                wr_idx <= (wr_idx == LAST_IDX) ? '0 : wr_idx + 1'b1;
                if (wr_idx == LAST_IDX) begin
                    wr_bank <= ~wr_bank;
                end
            end
            if (rd_fire) begin
                rd_idx <= (rd_idx == LAST_IDX) ? '0 : rd_idx + 1'b1;
                if (rd_idx == LAST_IDX) begin
                    rd_bank <= ~rd_bank;
                end
            end
        end
    end

endmodule

// File: tb/tb_inv_shift_rows_serial.sv
// Self-checking bench for inv_shift_rows_serial.
// The driver pushes expected bytes into a scoreboard queue.
// A separate monitor pops entries and compares them on every output handshake.
module tb_inv_shift_rows_serial;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_byte = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_byte;
    logic       out_last;

    int checks = 0;
    int errors = 0;
    int ready_mode = 1;   // 0: hold low, 1: hold high, 2: random
    int run_len = 0;
    int max_run = 0;
    int stalls = 0;

    logic [8:0] sb [$];   // {last, byte}

    logic [7:0] fips_in  [16] = '{8'hd4, 8'hbf, 8'h5d, 8'h30, 8'he0, 8'hb4, 8'h52, 8'hae,
                                  8'hb8, 8'h41, 8'h11, 8'hf1, 8'h1e, 8'h27, 8'h98, 8'he5};
    logic [7:0] fips_out [16] = '{8'hd4, 8'h27, 8'h11, 8'hae, 8'he0, 8'hbf, 8'h98, 8'hf1,
                                  8'hb8, 8'hb4, 8'h5d, 8'he5, 8'h1e, 8'h41, 8'h52, 8'h30};
    logic [7:0] ramp_out [16] = '{8'h00, 8'h0D, 8'h0A, 8'h07, 8'h04, 8'h01, 8'h0E, 8'h0B,
                                  8'h08, 8'h05, 8'h02, 8'h0F, 8'h0C, 8'h09, 8'h06, 8'h03};

    inv_shift_rows_serial dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_byte   (in_byte),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_byte  (out_byte),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Reference model: view the state as a 4x4 matrix of rows and columns.
    // Inverse rotates row r right by r; forward rotates it left by r.
    function automatic logic [127:0] row_rotate(input logic [127:0] s, input bit inverse);
        logic [7:0] m [4][4];
        logic [7:0] t;
        logic [127:0] res;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                m[r][c] = s[8*(r+4*c) +: 8];
        for (int r = 0; r < 4; r++) begin
            repeat (r) begin
                if (inverse) begin
                    t = m[r][3]; m[r][3] = m[r][2]; m[r][2] = m[r][1]; m[r][1] = m[r][0]; m[r][0] = t;
                end else begin
                    t = m[r][0]; m[r][0] = m[r][1]; m[r][1] = m[r][2]; m[r][2] = m[r][3]; m[r][3] = t;
                end
            end
        end
        res = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                res[8*(r+4*c) +: 8] = m[r][c];
        return res;
    endfunction

    function automatic logic [127:0] pack16(input logic [7:0] a [16]);
        logic [127:0] res;
        for (int i = 0; i < 16; i++) res[8*i +: 8] = a[i];
        return res;
    endfunction

    function automatic logic [127:0] rand_block();
        logic [127:0] res;
        for (int i = 0; i < 4; i++) res[32*i +: 32] = $urandom;
        return res;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) run_len++;
            else run_len = 0;
            if (run_len > max_run) max_run = run_len;
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: got byte %h last %b with empty scoreboard",
                             out_byte, out_last);
                end else begin
                    logic [8:0] exp;
                    exp = sb.pop_front();
                    if (out_byte !== exp[7:0] || out_last !== exp[8]) begin
                        errors++;
                        $display("FAIL out_byte: got %h last %b expected %h last %b",
                                 out_byte, out_last, exp[7:0], exp[8]);
                    end
                end
            end
        end
    end

    task automatic push_block(input logic [127:0] exp);
        for (int i = 0; i < 16; i++) sb.push_back({1'(i == 15), exp[8*i +: 8]});
    endtask

    // Called just after a rising edge; returns just after the edge on which
    // the byte was accepted.
    task automatic send_byte(input logic [7:0] b, input int gap);
        logic acc;
        int n;
        if (gap > 0) begin
            in_valid = 1'b0;
            repeat (gap) begin @(posedge clk); #1; end
        end
        in_valid = 1'b1;
        in_byte  = b;
        n = 0;
        do begin
            @(negedge clk);
            acc = in_ready;
            if (!acc) stalls++;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 2000);
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got in_ready 0 for %0d cycles expected acceptance", n);
        end
    endtask

    task automatic send_block(input logic [127:0] blk, input int gapmax);
        for (int i = 0; i < 16; i++)
            send_byte(blk[8*i +: 8], (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0);
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 5000) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain", sb.size(), 0);
    endtask

    initial begin
        logic [127:0] blk;
        logic [127:0] blk_b;
        logic [127:0] exp0;

        ready_mode = 1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_last", out_last, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // FIPS-197 vector; also check first-byte latency
        push_block(pack16(fips_out));
        send_block(pack16(fips_in), 0);
        idle();
        check("latency_out_valid", out_valid, 1);
        check("latency_first_byte", out_byte, 8'hd4);
        wait_drain();

        // Index ramp
        for (int i = 0; i < 16; i++) blk[8*i +: 8] = 8'(i);
        push_block(pack16(ramp_out));
        send_block(blk, 0);
        idle();
        wait_drain();

        // Back-to-back: three blocks, continuous valid and ready
        max_run = 0;
        stalls = 0;
        for (int k = 0; k < 3; k++) begin
            blk = rand_block();
            push_block(row_rotate(blk, 1'b1));
            send_block(blk, 0);
        end
        idle();
        wait_drain();
        check("b2b_stalls", stalls, 0);
        check("b2b_contiguous_valid", max_run, 48);

        // Backpressure: two blocks fill both banks, writer then blocks
        ready_mode = 0;
        @(posedge clk);
        #1;
        blk = rand_block();
        blk_b = rand_block();
        exp0 = row_rotate(blk, 1'b1);
        push_block(exp0);
        push_block(row_rotate(blk_b, 1'b1));
        send_block(blk, 0);
        send_block(blk_b, 0);
        in_valid = 1'b1;
        in_byte = 8'hAA;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("bp_in_ready", in_ready, 0);
            check("bp_out_valid", out_valid, 1);
            check("bp_out_byte_stable", out_byte, exp0[7:0]);
            @(posedge clk);
            #1;
        end
        idle();
        ready_mode = 1;
        wait_drain();

        // Random gaps on input and random backpressure
        ready_mode = 2;
        for (int k = 0; k < 4; k++) begin
            blk = rand_block();
            push_block(row_rotate(blk, 1'b1));
            send_block(blk, 2);
        end
        idle();
        wait_drain();

        // Reset mid-stream: block 1 draining, 7 bytes of block 2 written
        ready_mode = 1;
        @(posedge clk);
        #1;
        blk = rand_block();
        push_block(row_rotate(blk, 1'b1));
        send_block(blk, 0);
        for (int i = 0; i < 7; i++) send_byte(8'($urandom), 0);
        idle();
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_out_last", out_last, 0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        blk = rand_block();
        push_block(row_rotate(blk, 1'b1));
        send_block(blk, 0);
        idle();
        wait_drain();

        // Round trip: forward ShiftRows then the DUT restores the original
        ready_mode = 2;
        for (int k = 0; k < 5; k++) begin
            blk = rand_block();
            push_block(blk);
            send_block(row_rotate(blk, 1'b0), 1);
        end
        idle();
        ready_mode = 1;
        wait_drain();

        repeat (4) @(posedge clk);
        #1;
        check("final_idle_out_valid", out_valid, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
